// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the St.PU hazard controller: register/stall bus widths,
// stall bit positions, result-latency classes and the observational FSM states.
package hazard_ctrl_pkg;

    localparam int RegAddrBus = 5;
    localparam int StallBus   = 6;

    localparam int STALL_PC  = 0;
    localparam int STALL_IF  = 1;
    localparam int STALL_ID  = 2;
    localparam int STALL_EX  = 3;
    localparam int STALL_MEM = 4;
    localparam int STALL_WB  = 5;

    typedef logic [StallBus-1:0] stall_t;

    // Reserved class 3 is tracked exactly like a load.
    typedef enum logic [1:0] {
        LAT_ALU  = 2'd0,
        LAT_LOAD = 2'd1,
        LAT_MDU  = 2'd2,
        LAT_RSVD = 2'd3
    } lat_t;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HAZ  = 2'd1,
        ST_MDUW = 2'd2
    } state_t;

    function automatic stall_t stall_front();
        stall_t s;
        s = '0;
        s[STALL_PC] = 1'b1;
        s[STALL_IF] = 1'b1;
        s[STALL_ID] = 1'b1;
        return s;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// ID-stage <-> hazard controller signal bundle. valid/ready: there is no ready;
// ID presents a request with id_valid_i and must hold it while stall_o[STALL_ID] is high.
interface hazard_ctrl_if #(
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int CNTW = 32
);
    logic            id_valid_i;
    logic            reg1_read_i;
    logic            reg2_read_i;
    logic [AW-1:0]   reg1_addr_i;
    logic [AW-1:0]   reg2_addr_i;
    logic            wreg_i;
    logic [AW-1:0]   wd_i;
    logic [1:0]      lat_i;
    logic            clr_we_i;
    logic [AW-1:0]   clr_addr_i;
    logic            mdu_done_i;
    logic            flush_i;
    logic [5:0]      stall_o;
    logic            bubble_o;
    logic            mdu_busy_o;
    logic [NREG-1:0] busy_o;
    logic [1:0]      state_o;
    logic [CNTW-1:0] stall_cnt_o;

    modport slave (
        input  id_valid_i, reg1_read_i, reg2_read_i, reg1_addr_i, reg2_addr_i,
        input  wreg_i, wd_i, lat_i, clr_we_i, clr_addr_i, mdu_done_i, flush_i,
        output stall_o, bubble_o, mdu_busy_o, busy_o, state_o, stall_cnt_o
    );

    modport master (
        output id_valid_i, reg1_read_i, reg2_read_i, reg1_addr_i, reg2_addr_i,
        output wreg_i, wd_i, lat_i, clr_we_i, clr_addr_i, mdu_done_i, flush_i,
        input  stall_o, bubble_o, mdu_busy_o, busy_o, state_o, stall_cnt_o
    );

endinterface

// File: rtl/hazard_ctrl_scoreboard.sv
// Per-register busy bits with set/clear update and two bypassed lookup ports:
// a register released this cycle already reads as not busy.
module hazard_ctrl_scoreboard #(
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            set_en,
    input  logic [AW-1:0]   set_addr,
    input  logic            clr_en,
    input  logic [AW-1:0]   clr_addr,
    input  logic [AW-1:0]   rd_addr1,
    input  logic [AW-1:0]   rd_addr2,
    output logic            rd_busy1,
    output logic            rd_busy2,
    output logic [NREG-1:0] busy
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [NREG-1:0] clr_mask;
    logic [NREG-1:0] eff;

    always_comb begin
        clr_mask = '0;
        if (clr_en) clr_mask[clr_addr] = 1'b1;
    end

    assign eff = busy_q & ~clr_mask;

    // Set is applied after clear so the younger writer keeps the register busy.
    always_comb begin
        busy_d = eff;
        if (set_en && set_addr != '0) busy_d[set_addr] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) busy_q <= '0;
        else      busy_q <= busy_d;
    end

    assign rd_busy1 = eff[rd_addr1];
    assign rd_busy2 = eff[rd_addr2];
    assign busy     = busy_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: freezes PC/IF/ID and bubbles EX on data or MDU
// structural hazards, tracks MDU occupancy and counts stalled cycles.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int NREG = 32,
    parameter int AW   = RegAddrBus,
    parameter int CNTW = 32
) (
    input logic        clk,
    input logic        rst,
    hazard_ctrl_if.slave bus
);

    state_t          state;
    state_t          state_next;
    logic            mdu_busy;
    logic [CNTW-1:0] stall_cnt;
    logic [NREG-1:0] busy;
    logic            eb1;
    logic            eb2;
    logic            dh;
    logic            sh;
    logic            is_mdu;
    logic            issue;
    logic            track;
    stall_t          stall;
    logic            bubble;

    assign is_mdu = (bus.lat_i == LAT_MDU);
    assign dh     = bus.id_valid_i & ((bus.reg1_read_i & eb1) | (bus.reg2_read_i & eb2));
    // Any MDU-class instruction conflicts with a busy MDU, whether or not it writes back.
    assign sh     = bus.id_valid_i & is_mdu & mdu_busy & ~bus.mdu_done_i;
    assign issue  = bus.id_valid_i & ~dh & ~sh & ~bus.flush_i;
    assign track  = issue & bus.wreg_i & (bus.lat_i != LAT_ALU);

    hazard_ctrl_scoreboard #(.NREG(NREG), .AW(AW)) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .set_en   (track),
        .set_addr (bus.wd_i),
        .clr_en   (bus.clr_we_i),
        .clr_addr (bus.clr_addr_i),
        .rd_addr1 (bus.reg1_addr_i),
        .rd_addr2 (bus.reg2_addr_i),
        .rd_busy1 (eb1),
        .rd_busy2 (eb2),
        .busy     (busy)
    );

    // Reset forces the stall outputs low so a mid-stall reset releases the pipe at once.
    always_comb begin
        stall  = '0;
        bubble = 1'b0;
        if (rst) begin
            if (bus.flush_i) begin
                bubble = 1'b1;
            end else if (dh || sh) begin
                stall  = stall_front();
                bubble = 1'b1;
            end
        end
    end

    always_comb begin
        state_next = ST_RUN;
        if (bus.flush_i)  state_next = ST_RUN;
        else if (dh)      state_next = ST_HAZ;
        else if (sh)      state_next = ST_MDUW;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_RUN;
        else      state <= state_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                    mdu_busy <= 1'b0;
        else if (issue && is_mdu)    mdu_busy <= 1'b1;
        else if (bus.mdu_done_i)     mdu_busy <= 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stall_cnt <= '0;
        else if ((dh || sh) && !bus.flush_i && stall_cnt != '1)
            stall_cnt <= stall_cnt + 1'b1;
    end

    assign bus.stall_o     = stall;
    assign bus.bubble_o    = bubble;
    assign bus.mdu_busy_o  = mdu_busy;
    assign bus.busy_o      = busy;
    assign bus.state_o     = state;
    assign bus.stall_cnt_o = stall_cnt;

endmodule
